lstm_seq_ctrl: RTL and testbench
================================

// Module: lstm_seq_ctrl
// PURPOSE
//  Sequences one lstm_cell instance over an input sequence of seq_len time steps.
//  Owns the recurrent c/h state registers, feeds one sample per step into the cell and waits its latency.
//  Captures c_out/h_out and streams h out over a valid/ready interface. Sits between the sample source and the consumer; weights/biases are wired to the cell directly.
// PARAMETERS
//  DATA_WIDTH   16  fixed-point word width (Q(DATA_WIDTH-FRACT_WIDTH).FRACT_WIDTH)
//  FRACT_WIDTH  8   fractional bits; informational, no arithmetic here
//  LEN_WIDTH    10  width of seq_len / step counter
//  CELL_LAT     0   cell latency in cycles (0 = combinational cell)
// PORTS
//  clk          in   1           clock, rising edge
//  rst          in   1           asynchronous reset, active-low
//  start        in   1           begin a sequence (sampled only in IDLE)
//  seq_len      in   LEN_WIDTH   number of steps, sampled with start
//  c_init       in   DATA_WIDTH  initial cell state, sampled with start
//  h_init       in   DATA_WIDTH  initial hidden state, sampled with start
//  busy         out  1           high from accepted start until done
//  done         out  1           one-cycle pulse at sequence end
//  x_valid      in   1           input sample valid
//  x_data       in   DATA_WIDTH  input sample X
//  x_ready      out  1           controller can accept a sample
//  cell_x       out  DATA_WIDTH  to cell X
//  cell_c       out  DATA_WIDTH  to cell c_in
//  cell_h       out  DATA_WIDTH  to cell h_in
//  cell_c_out   in   DATA_WIDTH  from cell c_out
//  cell_h_out   in   DATA_WIDTH  from cell h_out
//  y_valid      out  1           output h valid
//  y_data       out  DATA_WIDTH  h for the completed step
//  y_last       out  1           qualifies y_valid: final step of sequence
//  y_ready      in   1           consumer accepts y
//  c_final      out  DATA_WIDTH  c_reg (final c after done)
//  h_final      out  DATA_WIDTH  h_reg (final h after done)
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; all registers and outputs 0 (busy, done, x_ready, y_valid, y_last,
//   cell_*, c_final, h_final, step count, latency count). Reset mid-sequence aborts with no done pulse.
//  FSM: IDLE -> WAIT_X -> COMPUTE -> OUTPUT -> (WAIT_X | FINISH) -> IDLE.
//  IDLE: x_ready=0. start=1: latch len, c_reg<=c_init, h_reg<=h_init, step<=0, busy<=1.
//   seq_len==0 -> FINISH directly (no sample taken, no y). else -> WAIT_X.
//  WAIT_X: x_ready=1 (registered). On x_valid&&x_ready: x_reg<=x_data, lat<=CELL_LAT, -> COMPUTE.
//  COMPUTE: x_ready=0; cell_x/cell_c/cell_h = x_reg/c_reg/h_reg, stable for the whole state.
//   lat!=0: lat--. lat==0: c_reg<=cell_c_out, h_reg<=cell_h_out, y_valid<=1, y_last<=(step==len-1), -> OUTPUT.
//   y_valid rises CELL_LAT+1 edges after the x handshake edge.
//  OUTPUT: y_data=h_reg; y_valid,y_data,y_last held while y_ready=0 (no new sample accepted: one step
//   in flight). On y_ready: y_valid<=0, step++; last -> FINISH, else -> WAIT_X.
//  FINISH: done=1 for exactly one cycle, busy<=0, -> IDLE. c_reg/h_reg retained until next start.
//  start outside IDLE is ignored; seq_len/c_init/h_init changes after latch have no effect.
//  Width rules: no arithmetic on data; words pass bit-exact. step compares against len-1 in LEN_WIDTH;
//   len = 2^LEN_WIDTH-1 max, no counter wrap.
// STRUCTURE
//  lstm_pkg: DATA_WIDTH/FRACT_WIDTH defaults, state enum (IDLE,WAIT_X,COMPUTE,OUTPUT,FINISH).
//  Sub-module lstm_lat_timer: loadable down-counter (load CELL_LAT, zero flag); rest is one FSM.
//  Top-level test wrapper instantiates lstm_seq_ctrl + lstm_cell with cell ports tied together.
// TESTING
//  1 Reset: rst=0 mid-COMPUTE -> all outputs 0 next sample, state IDLE, no done pulse.
//  2 seq_len=3, CELL_LAT=0, c_init=h_init=0x0000, stub cell (c_out=c_in+x, h_out=x); x=0x0100,0x0200,0x0300
//    -> y_data 0x0100,0x0200,0x0300; y_last only on 3rd; c_final=0x0600; done 1 cycle after 3rd y handshake.
//  3 CELL_LAT=3: y_valid exactly 4 edges after x handshake; cell_x/c/h constant during COMPUTE.
//  4 Backpressure: y_ready=0 for 5 cycles -> y_valid/y_data/y_last stable, x_ready=0 throughout.
//  5 seq_len=0 with start -> busy 1 cycle, done pulse, no x_ready, no y_valid.
//  6 start pulsed while busy (seq_len=1, then start with seq_len=5) -> ignored; exactly 1 y, then done.

Source files
------------

// File: rtl/lstm_pkg.sv
// Shared definitions for the LSTM sequence controller: default widths and the FSM state encoding.
package lstm_pkg;

  localparam int DATA_WIDTH  = 16;
  localparam int FRACT_WIDTH = 8;
  localparam int LEN_WIDTH   = 10;
  localparam int CELL_LAT    = 0;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT_X  = 3'd1,
    COMPUTE = 3'd2,
    OUTPUT  = 3'd3,
    FINISH  = 3'd4
  } state_e;

  // Width of a down-counter that must hold the value lat; never narrower than one bit.
  function automatic int lat_bits(input int lat);
    return (lat > 0) ? $clog2(lat + 1) : 1;
  endfunction

endpackage

// File: rtl/lstm_lat_timer.sv
// Loadable down-counter that marks when the cell latency has elapsed.
module lstm_lat_timer
  import lstm_pkg::*;
#(
  parameter int CELL_LAT = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int CW = lat_bits(CELL_LAT);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: load wins, otherwise count down and stick at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = CW'(CELL_LAT);
    end else if (dec && (cnt_q != {CW{1'b0}})) begin
      cnt_d = cnt_q - CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == {CW{1'b0}});

endmodule

// File: rtl/lstm_seq_ctrl.sv
// Steps an external lstm_cell over seq_len samples, owning the recurrent c/h state and
// streaming each step's h to a valid/ready consumer.
module lstm_seq_ctrl
  import lstm_pkg::*;
#(
  parameter int DATA_WIDTH = lstm_pkg::DATA_WIDTH,
  parameter int LEN_WIDTH  = lstm_pkg::LEN_WIDTH,
  parameter int CELL_LAT   = lstm_pkg::CELL_LAT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  seq_len,
  input  logic [DATA_WIDTH-1:0] c_init,
  input  logic [DATA_WIDTH-1:0] h_init,
  output logic                  busy,
  output logic                  done,
  input  logic                  x_valid,
  input  logic [DATA_WIDTH-1:0] x_data,
  output logic                  x_ready,
  output logic [DATA_WIDTH-1:0] cell_x,
  output logic [DATA_WIDTH-1:0] cell_c,
  output logic [DATA_WIDTH-1:0] cell_h,
  input  logic [DATA_WIDTH-1:0] cell_c_out,
  input  logic [DATA_WIDTH-1:0] cell_h_out,
  output logic                  y_valid,
  output logic [DATA_WIDTH-1:0] y_data,
  output logic                  y_last,
  input  logic                  y_ready,
  output logic [DATA_WIDTH-1:0] c_final,
  output logic [DATA_WIDTH-1:0] h_final
);

  state_e state_q, state_d;

  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  step_q, step_d;
  logic [DATA_WIDTH-1:0] c_q, c_d;
  logic [DATA_WIDTH-1:0] h_q, h_d;
  logic [DATA_WIDTH-1:0] x_q, x_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  x_ready_q, x_ready_d;
  logic                  y_valid_q, y_valid_d;
  logic                  y_last_q, y_last_d;

  logic timer_load_s;
  logic timer_dec_s;
  logic lat_zero_s;
  logic x_fire_s;
  logic y_fire_s;

  lstm_lat_timer #(
    .CELL_LAT (CELL_LAT)
  ) u_lat_timer (
    .clk  (clk),
    .rst  (rst),
    .load (timer_load_s),
    .dec  (timer_dec_s),
    .zero (lat_zero_s)
  );

  assign x_fire_s = (state_q == WAIT_X) && x_valid && x_ready_q;
  assign y_fire_s = (state_q == OUTPUT) && y_valid_q && y_ready;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (seq_len == {LEN_WIDTH{1'b0}}) ? FINISH : WAIT_X;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_X: begin
        if (x_fire_s) state_d = COMPUTE;
        else          state_d = WAIT_X;
      end
      COMPUTE: begin
        if (lat_zero_s) state_d = OUTPUT;
        else            state_d = COMPUTE;
      end
      OUTPUT: begin
        if (y_fire_s) state_d = y_last_q ? FINISH : WAIT_X;
        else          state_d = OUTPUT;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered-output next values; outputs change only on the transitions above.
  always_comb begin
    len_d        = len_q;
    step_d       = step_q;
    c_d          = c_q;
    h_d          = h_q;
    x_d          = x_q;
    busy_d       = busy_q;
    done_d       = done_q;
    x_ready_d    = x_ready_q;
    y_valid_d    = y_valid_q;
    y_last_d     = y_last_q;
    timer_load_s = 1'b0;
    timer_dec_s  = 1'b0;
    case (state_q)
      IDLE: begin
        x_ready_d = 1'b0;
        done_d    = 1'b0;
        if (start) begin
          len_d     = seq_len;
          c_d       = c_init;
          h_d       = h_init;
          step_d    = {LEN_WIDTH{1'b0}};
          busy_d    = 1'b1;
          x_ready_d = (seq_len != {LEN_WIDTH{1'b0}});
          done_d    = (seq_len == {LEN_WIDTH{1'b0}});
        end else begin
          busy_d = busy_q;
        end
      end
      WAIT_X: begin
        if (x_fire_s) begin
          x_d          = x_data;
          x_ready_d    = 1'b0;
          timer_load_s = 1'b1;
        end else begin
          x_ready_d = 1'b1;
        end
      end
      COMPUTE: begin
        if (lat_zero_s) begin
          c_d       = cell_c_out;
          h_d       = cell_h_out;
          y_valid_d = 1'b1;
          y_last_d  = (step_q == (len_q - LEN_WIDTH'(1)));
        end else begin
          timer_dec_s = 1'b1;
        end
      end
      OUTPUT: begin
        if (y_fire_s) begin
          y_valid_d = 1'b0;
          y_last_d  = 1'b0;
          step_d    = step_q + LEN_WIDTH'(1);
          if (y_last_q) done_d = 1'b1;
          else          x_ready_d = 1'b1;
        end else begin
          y_valid_d = 1'b1;
        end
      end
      FINISH: begin
        done_d = 1'b0;
        busy_d = 1'b0;
      end
      default: begin
        busy_d    = 1'b0;
        done_d    = 1'b0;
        x_ready_d = 1'b0;
        y_valid_d = 1'b0;
        y_last_d  = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q     <= {LEN_WIDTH{1'b0}};
      step_q    <= {LEN_WIDTH{1'b0}};
      c_q       <= {DATA_WIDTH{1'b0}};
      h_q       <= {DATA_WIDTH{1'b0}};
      x_q       <= {DATA_WIDTH{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      x_ready_q <= 1'b0;
      y_valid_q <= 1'b0;
      y_last_q  <= 1'b0;
    end else begin
      len_q     <= len_d;
      step_q    <= step_d;
      c_q       <= c_d;
      h_q       <= h_d;
      x_q       <= x_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      x_ready_q <= x_ready_d;
      y_valid_q <= y_valid_d;
      y_last_q  <= y_last_d;
    end
  end

  // Cell inputs come straight from the state registers, so they cannot move during COMPUTE.
  assign cell_x  = x_q;
  assign cell_c  = c_q;
  assign cell_h  = h_q;
  assign y_data  = h_q;
  assign c_final = c_q;
  assign h_final = h_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign x_ready = x_ready_q;
  assign y_valid = y_valid_q;
  assign y_last  = y_last_q;

endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// Scoreboard bench for lstm_seq_ctrl with a stub cell (c_out = c_in + x, h_out = x).
module tb_lstm_seq_ctrl;

  localparam int DW  = 16;
  localparam int LW  = 10;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] seq_len = '0;
  logic [DW-1:0] c_init = '0;
  logic [DW-1:0] h_init = '0;
  logic          busy, done;
  logic          x_valid = 1'b0;
  logic [DW-1:0] x_data = '0;
  logic          x_ready;
  logic [DW-1:0] cell_x, cell_c, cell_h, cell_c_out, cell_h_out;
  logic          y_valid, y_last;
  logic [DW-1:0] y_data;
  logic          y_ready = 1'b0;
  logic [DW-1:0] c_final, h_final;

  lstm_seq_ctrl #(.DATA_WIDTH(DW), .LEN_WIDTH(LW), .CELL_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .seq_len(seq_len), .c_init(c_init), .h_init(h_init),
    .busy(busy), .done(done), .x_valid(x_valid), .x_data(x_data), .x_ready(x_ready),
    .cell_x(cell_x), .cell_c(cell_c), .cell_h(cell_h),
    .cell_c_out(cell_c_out), .cell_h_out(cell_h_out),
    .y_valid(y_valid), .y_data(y_data), .y_last(y_last), .y_ready(y_ready),
    .c_final(c_final), .h_final(h_final)
  );

  assign cell_c_out = cell_c + cell_x;
  assign cell_h_out = cell_x;

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } y_t;

  y_t   exp_q[$];
  y_t   exp_e;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   y_cnt = 0;
  int   done_cnt = 0;
  int   hs_cyc = 0;
  int   y_rise_cyc = 0;
  int   last_hs_cyc = 0;
  int   done_cyc = 0;
  int   y0, d0;
  logic yv_prev = 1'b0;
  logic done_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: compares every y handshake against the scoreboard and watches the done pulse.
  always @(negedge clk) begin
    if (!rst) begin
      yv_prev   = 1'b0;
      done_prev = 1'b0;
    end else begin
      if (y_valid && !yv_prev) y_rise_cyc = cyc;
      if (y_valid && y_ready) begin
        y_cnt++;
        last_hs_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL y_unexpected: got y_data 0x%0h with no expected entry", y_data);
        end else begin
          exp_e = exp_q.pop_front();
          check("y_data", y_data, exp_e.data);
          check("y_last", y_last, exp_e.last);
        end
      end
      if (done) begin
        done_cnt++;
        check("done_width", done_prev, 1'b0);
      end
      yv_prev   = y_valid;
      done_prev = done;
    end
  end

  task automatic go(input logic [LW-1:0] l, input logic [DW-1:0] c, input logic [DW-1:0] h);
    start = 1'b1; seq_len = l; c_init = c; h_init = h;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_x(input logic [DW-1:0] v, input bit push, input bit last);
    int k = 0;
    x_valid = 1'b1;
    x_data  = v;
    while (!x_ready && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    if (!x_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL x_timeout: got x_ready 0 expected 1 within 50 cycles");
      x_valid = 1'b0;
    end else begin
      if (push) exp_q.push_back({v, last});
      @(posedge clk); #1;
      hs_cyc  = cyc;
      x_valid = 1'b0;
      x_data  = '0;
    end
  endtask

  task automatic wait_done();
    int k = 0;
    while (!done && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got done 0 expected 1 within 100 cycles");
    end else begin
      done_cyc = cyc;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_x_ready", x_ready, 1'b0);
    check("rst_y_valid", y_valid, 1'b0);
    check("rst_y_last", y_last, 1'b0);
    check("rst_cell_x", cell_x, 16'h0000);
    check("rst_cell_c", cell_c, 16'h0000);
    check("rst_cell_h", cell_h, 16'h0000);
    check("rst_y_data", y_data, 16'h0000);
    check("rst_c_final", c_final, 16'h0000);
    check("rst_h_final", h_final, 16'h0000);
    rst = 1'b1;
    @(posedge clk); #1;

    // Reset asserted while the cell latency is still counting
    y_ready = 1'b1;
    d0 = done_cnt;
    go(10'd2, 16'h1111, 16'h2222);
    send_x(16'h0abc, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_x_ready", x_ready, 1'b0);
    check("abort_y_valid", y_valid, 1'b0);
    check("abort_cell_x", cell_x, 16'h0000);
    check("abort_c_final", c_final, 16'h0000);
    check("abort_h_final", h_final, 16'h0000);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("abort_idle_busy", busy, 1'b0);
    check("abort_idle_x_ready", x_ready, 1'b0);
    check("abort_no_done", done_cnt - d0, 0);

    // Three-step sequence, accumulate c
    y0 = y_cnt;
    go(10'd3, 16'h0000, 16'h0000);
    send_x(16'h0100, 1'b1, 1'b0);
    send_x(16'h0200, 1'b1, 1'b0);
    send_x(16'h0300, 1'b1, 1'b1);
    wait_done();
    check("seq3_c_final", c_final, 16'h0600);
    check("seq3_h_final", h_final, 16'h0300);
    check("seq3_done_timing", done_cyc, last_hs_cyc + 1);
    check("seq3_y_count", y_cnt - y0, 3);
    check("seq3_sb_empty", exp_q.size(), 0);

    // Latency and cell input stability
    go(10'd1, 16'h0010, 16'h0020);
    send_x(16'h0a0b, 1'b1, 1'b1);
    for (int i = 0; i <= LAT; i++) begin
      @(negedge clk);
      check("compute_cell_x", cell_x, 16'h0a0b);
      check("compute_cell_c", cell_c, 16'h0010);
      check("compute_cell_h", cell_h, 16'h0020);
    end
    wait_done();
    check("latency", y_rise_cyc - hs_cyc, LAT + 1);
    check("lat_c_final", c_final, 16'h0a1b);

    // Backpressure holds the output and blocks new samples
    y_ready = 1'b0;
    go(10'd2, 16'h0005, 16'h0006);
    send_x(16'h0007, 1'b1, 1'b0);
    begin
      int k = 0;
      while (!y_valid && k < 20) begin
        @(negedge clk);
        k++;
      end
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_y_valid", y_valid, 1'b1);
      check("bp_y_data", y_data, 16'h0007);
      check("bp_y_last", y_last, 1'b0);
      check("bp_x_ready", x_ready, 1'b0);
    end
    y_ready = 1'b1;
    send_x(16'h0008, 1'b1, 1'b1);
    wait_done();
    check("bp_c_final", c_final, 16'h0014);
    check("bp_h_final", h_final, 16'h0008);

    // Zero-length sequence
    y0 = y_cnt;
    d0 = done_cnt;
    go(10'd0, 16'h00aa, 16'h00bb);
    check("len0_busy", busy, 1'b1);
    check("len0_done", done, 1'b1);
    check("len0_x_ready", x_ready, 1'b0);
    check("len0_c_final", c_final, 16'h00aa);
    @(posedge clk); #1;
    check("len0_busy_end", busy, 1'b0);
    check("len0_done_end", done, 1'b0);
    check("len0_y_valid", y_valid, 1'b0);
    check("len0_done_count", done_cnt - d0, 1);
    check("len0_y_count", y_cnt - y0, 0);

    // start while busy is ignored
    y0 = y_cnt;
    d0 = done_cnt;
    go(10'd1, 16'h0000, 16'h0000);
    start   = 1'b1;
    seq_len = 10'd5;
    @(posedge clk); #1;
    start   = 1'b0;
    seq_len = 10'd0;
    send_x(16'h0033, 1'b1, 1'b1);
    wait_done();
    check("ign_y_count", y_cnt - y0, 1);
    check("ign_done_count", done_cnt - d0, 1);
    repeat (3) @(posedge clk);
    #1;
    check("ign_busy_after", busy, 1'b0);
    check("ign_x_ready_after", x_ready, 1'b0);
    check("ign_h_final", h_final, 16'h0033);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
